// File: rtl/packet_tx.sv
// packet_tx: reads one packet from a synchronous packet buffer and transmits it.
// Read data passes through a 2-entry skid buffer so that downstream stalls lose
// nothing. When the skid buffer is empty, a word that arrives from the buffer
// goes straight to the output register.
// Optional feature macro: PACKET_TX_STATS_EN compiles in the pkt_count and
// word_count statistics counters. Without it, both outputs are tied to zero.
//
// state | meaning
// IDLE  | waiting for start; start is ignored during the cycle that done is high
// RUN   | issuing reads and popping words to the output
// DONE  | last word sent; pulse done, drop busy, return to IDLE
module packet_tx #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [CTRL_W-1:0] rd_ctrl,
    input  logic              out_rdy,
    output logic              out_wr,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pkt_count,
    output logic [15:0]       word_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] end_addr_q;
    logic [ADDR_W:0]   words_left;
    logic              reads_done;
    logic              rd_valid;
    logic [1:0]        skid_cnt;
    logic [DATA_W-1:0] skid_d0, skid_d1;
    logic [CTRL_W-1:0] skid_c0, skid_c1;

    logic [1:0]        avail;
    logic              pop;
    logic              issue;
    logic [DATA_W-1:0] head_d;
    logic [CTRL_W-1:0] head_c;

    // Words available this edge: skid buffer contents plus any word arriving from
    // the read that was issued last cycle. A new read is issued only if the buffer
    // can still hold it after this edge's pop.
    always_comb begin
        avail  = skid_cnt + {1'b0, rd_valid};
        pop    = (state == RUN) && out_rdy && (avail != 2'd0);
        issue  = (state == RUN) && !reads_done && ({1'b0, avail} < (3'd2 + {2'b0, pop}));
        head_d = (skid_cnt != 2'd0) ? skid_d0 : rd_data;
        head_c = (skid_cnt != 2'd0) ? skid_c0 : rd_ctrl;
    end

    // Sequencer, read issue, skid buffer, and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            end_addr_q <= '0;
            words_left <= '0;
            reads_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_addr    <= '0;
            skid_cnt   <= 2'd0;
            skid_d0    <= '0;
            skid_d1    <= '0;
            skid_c0    <= '0;
            skid_c1    <= '0;
            out_wr     <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rd_valid <= issue;
            case (state)
                IDLE: begin
                    out_wr <= 1'b0;
                    done   <= 1'b0;
                    if (start && !done) begin
                        end_addr_q <= end_addr;
                        rd_addr    <= start_addr;
                        words_left <= {1'b0, end_addr - start_addr} + (ADDR_W+1)'(1);
                        reads_done <= 1'b0;
                        skid_cnt   <= 2'd0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    out_wr <= pop;
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (rd_addr == end_addr_q)
                            reads_done <= 1'b1;
                    end
                    if (pop) begin
                        out_data   <= head_d;
                        out_ctrl   <= head_c;
                        words_left <= words_left - (ADDR_W+1)'(1);
                        if (words_left == (ADDR_W+1)'(1))
                            state <= DONE;
                        case (skid_cnt)
                            2'd0: ;
                            2'd1: begin
                                if (rd_valid) begin
                                    skid_d0 <= rd_data;
                                    skid_c0 <= rd_ctrl;
                                end
                                skid_cnt <= {1'b0, rd_valid};
                            end
                            default: begin
                                skid_d0  <= skid_d1;
                                skid_c0  <= skid_c1;
                                skid_cnt <= 2'd1;
                            end
                        endcase
                    end else if (rd_valid) begin
                        if (skid_cnt == 2'd0) begin
                            skid_d0 <= rd_data;
                            skid_c0 <= rd_ctrl;
                        end else begin
                            skid_d1 <= rd_data;
                            skid_c1 <= rd_ctrl;
                        end
                        skid_cnt <= skid_cnt + 2'd1;
                    end
                end
                DONE: begin
                    out_wr <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    out_wr <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef PACKET_TX_STATS_EN
    // Wrapping statistics: packets counted on entry to DONE, words on each pop
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count  <= '0;
            word_count <= '0;
        end else begin
            if (state == DONE)
                pkt_count <= pkt_count + 16'd1;
            if (pop)
                word_count <= word_count + 16'd1;
        end
    end
`else
    assign pkt_count  = 16'd0;
    assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: a buffer model feeds the DUT, and an expected-word queue,
// built from the packet address range, is checked on every cycle.
module tb_packet_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = '0;
    logic [7:0]  end_addr = '0;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [7:0]  rd_ctrl;
    logic        out_rdy = 1'b0;
    logic        out_wr;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic [15:0] word_count;

    packet_tx #(.DATA_W(64), .CTRL_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ctrl(rd_ctrl),
        .out_rdy(out_rdy), .out_wr(out_wr), .out_data(out_data), .out_ctrl(out_ctrl),
        .busy(busy), .done(done), .pkt_count(pkt_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mem_d [256];
    logic [7:0]  mem_c [256];

    always @(posedge clk) begin
        rd_data <= mem_d[rd_addr];
        rd_ctrl <= mem_c[rd_addr];
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rdy_s = 1'b0;
    logic rst_s = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdy_s <= out_rdy;
        rst_s <= reset;
    end

    logic [71:0] exp_q[$];
    logic [7:0]  seen_lo[$];
    logic [63:0] last_data = '0;
    logic [7:0]  last_ctrl = '0;
    logic [63:0] first_data = '0;
    logic [7:0]  first_ctrl = '0;
    bit          done_due = 0;
    int          pkt_wr = 0;
    int          first_wr_cyc = 0;
    int          last_wr_cyc = 0;
    logic [15:0] model_pkts = '0;
    logic [15:0] model_words = '0;

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Per-cycle compare against the expected-word queue
    always @(negedge clk) begin
        logic [71:0] e;
        if (rst_s) begin
            check("rst_out_wr", out_wr, 0);
            check("rst_out_word", {out_ctrl, out_data}, 0);
            check("rst_busy_done", {busy, done}, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_counters", {pkt_count, word_count}, 0);
            exp_q.delete();
            done_due    = 0;
            last_data   = '0;
            last_ctrl   = '0;
            model_pkts  = '0;
            model_words = '0;
        end else begin
            check("done", done, done_due);
            done_due = 0;
            if (done) begin
                check("busy_at_done", busy, 0);
                model_pkts = model_pkts + 16'd1;
            end
            if (out_wr) begin
                check("wr_only_when_rdy", rdy_s, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", {out_ctrl, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("word", {out_ctrl, out_data}, e);
                    if (exp_q.size() == 0) done_due = 1;
                end
                if (pkt_wr == 0) begin
                    first_wr_cyc = cyc;
                    first_data   = out_data;
                    first_ctrl   = out_ctrl;
                end
                last_wr_cyc = cyc;
                pkt_wr++;
                seen_lo.push_back(out_data[7:0]);
                model_words = model_words + 16'd1;
            end else begin
                check("hold", {out_ctrl, out_data}, {last_ctrl, last_data});
            end
            last_data = out_data;
            last_ctrl = out_ctrl;
`ifdef PACKET_TX_STATS_EN
            check("pkt_count", pkt_count, model_pkts);
            check("word_count", word_count, model_words);
`else
            check("stats_off", {pkt_count, word_count}, 0);
`endif
        end
    end

    function automatic logic rdy_pat(input int mode, input int n);
        if (mode == 0) return 1'b1;
        case ((n - 1) % 6)
            0: return 1'b1;
            1: return 1'b0;
            2: return 1'b0;
            3: return 1'b1;
            4: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic load_expected(input logic [7:0] sa, input logic [7:0] ea, input int exp_len, input string nm);
        logic [7:0] diff;
        logic [7:0] a;
        int         len;
        diff = ea - sa;
        len  = int'(diff) + 1;
        check({nm, "_len"}, len, exp_len);
        for (int i = 0; i < len; i++) begin
            a = sa + 8'(i);
            exp_q.push_back({mem_c[a], mem_d[a]});
        end
        pkt_wr = 0;
        seen_lo.delete();
    endtask

    // One packet: mode 0 holds out_rdy high, mode 1 toggles it. poke issues a stray
    // start while busy; done_poke issues a start during the done cycle.
    task automatic run_pkt(input logic [7:0] sa, input logic [7:0] ea, input int mode,
                           input int exp_len, input string nm, input bit poke, input bit done_poke);
        int s;
        int n;
        int guard;
        load_expected(sa, ea, exp_len, nm);
        @(posedge clk); #1;
        start = 1'b1; start_addr = sa; end_addr = ea; out_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        check({nm, "_busy_after_start"}, busy, 1);
        n = 1;
        guard = 0;
        while (!done && guard < 400) begin
            out_rdy = rdy_pat(mode, n);
            start = poke && (n == 3);
            start_addr = 8'h80; end_addr = 8'h83;
            n++;
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        out_rdy = 1'b1;
        if (guard >= 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", nm);
        end
        check({nm, "_word_total"}, pkt_wr, exp_len);
        check({nm, "_queue_drained"}, exp_q.size(), 0);
        if (mode == 0) begin
            check({nm, "_first_latency"}, first_wr_cyc - s, 2);
            check({nm, "_no_gaps"}, last_wr_cyc - first_wr_cyc + 1, exp_len);
        end
        if (done_poke) begin
            start = 1'b1; start_addr = 8'h90; end_addr = 8'h91;
            @(posedge clk); #1;
            start = 1'b0;
            check({nm, "_start_in_done_ignored"}, busy, 0);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 256; i++) begin
            mem_d[i] = 64'h0123_4567_89AB_CD00 + 64'(i) * 64'h0001_0000_0000_0001;
            mem_c[i] = 8'(i) ^ 8'hA5;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        run_pkt(8'h10, 8'h10, 0, 1, "single", 0, 1);
        check("single_data_literal", first_data, 64'h0133_4567_89AB_CD10);
        check("single_ctrl_literal", first_ctrl, 8'hB5);

        run_pkt(8'h00, 8'h07, 0, 8, "b2b", 1, 0);

        run_pkt(8'hFE, 8'h01, 0, 4, "wrap", 0, 0);
        if (seen_lo.size() == 4) begin
            check("wrap_order0", seen_lo[0], 8'hFE);
            check("wrap_order1", seen_lo[1], 8'hFF);
            check("wrap_order2", seen_lo[2], 8'h00);
            check("wrap_order3", seen_lo[3], 8'h01);
        end else begin
            check("wrap_seen_count", seen_lo.size(), 4);
        end

        run_pkt(8'h40, 8'h45, 1, 6, "bp", 0, 0);

        // Abort: reset after the third word of an 8-word packet
        load_expected(8'h20, 8'h27, 8, "abort");
        @(posedge clk); #1;
        start = 1'b1; start_addr = 8'h20; end_addr = 8'h27; out_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        guard = 0;
        while (pkt_wr < 3 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        check("abort_reached_third", pkt_wr, 3);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_more_words", pkt_wr, 3);

        run_pkt(8'h30, 8'h32, 0, 3, "stats_a", 0, 0);
        run_pkt(8'h50, 8'h54, 1, 5, "stats_b", 0, 0);
        @(posedge clk); #1;
`ifdef PACKET_TX_STATS_EN
        check("stats_pkt_literal", pkt_count, 16'd2);
        check("stats_word_literal", word_count, 16'd8);
`else
        check("stats_off_literal", {pkt_count, word_count}, 32'd0);
`endif

        repeat (5) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
